// File: rtl/popcount_pkg.sv
// popcount_pkg: shared FSM state type and width helper for the sequential popcount block.
//   count_width(w) - bits needed to hold any count from 0 to w inclusive
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcount_lut.sv
// popcount_lut: combinational population count of one CHUNK-bit slice.
//   bits  - input slice
//   count - number of set bits in the slice, 0..CHUNK
module popcount_lut #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]               bits,
    output logic [$clog2(CHUNK+1)-1:0]     count
);

    localparam int CW = $clog2(CHUNK + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcount_seq.sv
// popcount_seq: counts the ones (or zeros) of a WIDTH-bit word, CHUNK bits per clock.
//   clk, rst              - clock and asynchronous active-high reset
//   in_valid / in_ready   - input handshake; a word is accepted only in IDLE
//   bits, count_zeros     - word to count and mode (1 = count zeros), sampled at accept
//   out_valid / out_ready - result handshake; the result is held in DONE until taken
//   count                 - accumulator, meaningful while out_valid is high
//   busy                  - high while chunks are being counted
module popcount_seq
    import popcount_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CHUNK = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  bits,
    input  logic                              count_zeros,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [count_width(WIDTH)-1:0]     count,
    output logic                              busy
);

    localparam int NCHUNK  = WIDTH / CHUNK;
    localparam int COUNT_W = count_width(WIDTH);
    localparam int LUT_W   = $clog2(CHUNK + 1);
    localparam int CNT_W   = $clog2(NCHUNK + 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("popcount_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [COUNT_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [LUT_W-1:0]   lut_cnt;

    popcount_lut #(.CHUNK(CHUNK)) u_lut (
        .bits  (shreg_q[CHUNK-1:0]),
        .count (lut_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Zero counting is done by inverting the word once at accept, so the
    // datapath only ever counts ones.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    shreg_d = count_zeros ? ~bits : bits;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                acc_d   = acc_q + COUNT_W'(lut_cnt);
                shreg_d = shreg_q >> CHUNK;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NCHUNK - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign count     = acc_q;

endmodule

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: randomized and directed checks of popcount_seq against a countdown model.
module tb_popcount_seq;

    localparam int W = 12;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, count_zeros = 1'b0, out_ready = 1'b0;
    logic [W-1:0] bits = '0;
    logic        in_ready, out_valid, busy;
    logic [3:0]  count;

    logic        v16 = 1'b0, cz16 = 1'b0, or16 = 1'b1;
    logic [15:0] b16 = '0;
    logic        r16, ov16, busy16;
    logic [4:0]  c16;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    popcount_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bits(bits), .count_zeros(count_zeros), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .busy(busy)
    );

    popcount_seq #(.WIDTH(16), .CHUNK(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
        .bits(b16), .count_zeros(cz16), .out_valid(ov16),
        .out_ready(or16), .count(c16), .busy(busy16)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pc(input logic [W-1:0] w);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(w[i]);
        return n;
    endfunction

    // Model: an accepted word's result appears N edges later and stays until taken.
    int m_left = 0;
    bit m_done = 1'b0;
    int m_res  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (in_valid) begin
            m_res  = pc(count_zeros ? ~bits : bits);
            m_left = N;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", int'(in_ready), int'(!m_done && m_left == 0));
            chk("out_valid", int'(out_valid), int'(m_done));
            chk("busy", int'(busy), int'(m_left > 0));
            if (m_done) chk("count", int'(count), m_res);
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [W-1:0] b, input logic cz);
        int t = 0;
        bits = b;
        count_zeros = cz;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin step(); t++; end
        chk("issue_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp, input int lat);
        int t = 0;
        while (!out_valid && t < 20) begin step(); t++; end
        chk({name, "_latency"}, t, lat);
        chk(name, int'(count), exp);
    endtask

    task automatic consume;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run16(input logic [15:0] b, input int exp);
        int t = 0;
        b16 = b;
        v16 = 1'b1;
        chk("w16_ready", int'(r16), 1);
        step();
        v16 = 1'b0;
        while (!ov16 && t < 20) begin step(); t++; end
        chk("w16_latency", t, 2);
        chk("w16_count", int'(c16), exp);
        step();
    endtask

    initial begin
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        step();
        rst = 1'b0;

        issue(12'b111111111111, 1'b0);
        wait_result("all_ones", 12, N);
        consume();

        issue(12'b010110101101, 1'b0);
        wait_result("ones_a", 7, N);
        consume();
        issue(12'b100001011100, 1'b0);
        wait_result("ones_b", 5, N);
        consume();

        issue(12'b100001011100, 1'b1);
        wait_result("zeros", 7, N);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_count", int'(count), 7);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        consume();

        issue(12'hABC, 1'b0);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(count), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_valid", int'(out_valid), 0);
        end
        issue(12'h001, 1'b0);
        wait_result("after_abort", 1, N);
        consume();

        issue(12'h0F0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            bits = 12'hFFF;
            count_zeros = 1'b1;
            step();
            in_valid = 1'b0;
        end
        chk("ignore_busy", int'(count), 4);
        consume();

        run16(16'h0000, 0);
        run16(16'hFFFF, 16);

        for (int i = 0; i < 3000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            bits = W'($urandom);
            count_zeros = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b0;

        for (int v = 0; v < 4096; v++) begin
            issue(W'(v), 1'b0);
            wait_result("sweep", $countones(W'(v)), N);
            consume();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount_seq.md
POPCOUNT_SEQ -- requirements
Module: popcount_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, the input word width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, the number of bits counted per clock cycle.
REQ-003 The block SHALL have derived constants NCHUNK = WIDTH/CHUNK and COUNT_W = $clog2(WIDTH+1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: bits and count_zeros are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-008 The block SHALL have port bits, input, WIDTH bits: the word to count.
REQ-009 The block SHALL have port count_zeros, input, 1 bit: 0 = count ones, 1 = count zeros.
REQ-010 The block SHALL have port out_valid, output, 1 bit: count holds a finished result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port count, output, COUNT_W bits: the result.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state BUSY.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, BUSY, DONE.
REQ-015 The block SHALL hold in_ready = 1 in IDLE only, and 0 in BUSY and DONE.
REQ-016 The block SHALL treat an accept as in_valid && in_ready at a clock edge.
REQ-017 On accept, the block SHALL load the shift register with bits (inverted if count_zeros = 1), clear the accumulator and chunk counter, and go to BUSY.
REQ-018 Each BUSY cycle, the block SHALL add popcount(shreg[CHUNK-1:0]) to the accumulator, shift shreg right by CHUNK, and increment the chunk counter.
REQ-019 After NCHUNK BUSY cycles, the block SHALL go to DONE with count = final accumulator and out_valid = 1.
REQ-020 Latency SHALL be: accept at edge k gives out_valid high after edge k+NCHUNK (3 cycles at default parameters).
REQ-021 In DONE, count and out_valid SHALL hold stable until out_ready = 1 at an edge; the block then returns to IDLE with out_valid = 0.
REQ-022 The block SHALL NOT accept a new word in the same cycle a result is consumed; in_ready rises the cycle after consumption, giving a minimum issue interval of NCHUNK+2 cycles.
REQ-023 The block SHALL ignore in_valid, bits and count_zeros outside IDLE; the mode is captured at accept only.
REQ-024 The block SHALL ignore out_ready outside DONE.
REQ-025 The accumulator SHALL be COUNT_W bits wide and SHALL NOT overflow; all-ones at any legal WIDTH gives count = WIDTH.
REQ-026 count SHALL show the accumulator at all times; it is defined only while out_valid = 1.
REQ-027 Elaboration SHALL fail if WIDTH % CHUNK != 0, CHUNK < 1 or CHUNK > WIDTH.
REQ-028 With CHUNK = WIDTH, NCHUNK SHALL be 1 and latency SHALL be 1 cycle.

Reset
REQ-029 When rst = 1, the block SHALL immediately (asynchronously) force state = IDLE, in_ready = 1, out_valid = 0, busy = 0, count = 0, shift register = 0, and chunk counter = 0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation; the partial result is discarded and no out_valid pulse appears.
REQ-031 After rst deasserts, the first accept SHALL be possible at the next rising edge.

Structure
REQ-032 A shared package popcount_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and a count_width(w) function returning $clog2(w+1).
REQ-033 The block SHALL use one combinational sub-module, popcount_lut, parameterised by CHUNK, with input bits[CHUNK] and output count[$clog2(CHUNK+1)]; it is instantiated once.
REQ-034 Target size SHALL be 150-250 lines of RTL, excluding the package.

Verification
REQ-035 Scenario: default parameters, 12'b111111111111, count_zeros = 0 -> out_valid after 3 cycles, count = 12.
REQ-036 Scenario: 12'b010110101101 then 12'b100001011100, ones mode -> count = 7, then count = 5, each after its own accept.
REQ-037 Scenario: 12'b100001011100, count_zeros = 1 -> count = 7; out_ready held low 5 cycles -> count and out_valid stable, in_ready = 0 throughout.
REQ-038 Scenario: rst asserted mid-BUSY (after cycle 2) -> all outputs reset that same cycle, no out_valid; next word 12'h001 -> count = 1.
REQ-039 Scenario: in_valid toggling while BUSY, with different bits -> result reflects only the accepted word.
REQ-040 Scenario: WIDTH = 16, CHUNK = 8, inputs 16'h0000 then 16'hFFFF -> count = 0 and count = 16, each 2 cycles after its accept; also run an exhaustive 0..4095 sweep at defaults against a software popcount.
